// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter: shares one registered-output ALU between NUM_REQ valid/ready
// requesters. Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int width   = 16,
    parameter int width2  = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*width-1:0] req_a,
    input  logic [NUM_REQ*width-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]    req_fun,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [width2-1:0]       rsp_data,
    output logic                    rsp_flag,
    output logic [2:0]              rsp_id,
    output logic                    busy,
    output logic [width-1:0]        alu_a,
    output logic [width-1:0]        alu_b,
    output logic [3:0]              alu_fun,
    input  logic [width2-1:0]       alu_arith_out,
    input  logic                    alu_arith_flag,
    input  logic [width-1:0]        alu_logic_out,
    input  logic [width-1:0]        alu_cmp_out,
    input  logic [width-1:0]        alu_shift_out,
    input  logic                    alu_logic_flag,
    input  logic                    alu_cmp_flag,
    input  logic                    alu_shift_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          ptr;
    logic                grant_hit, hit_hi;
    logic [2:0]          grant_idx, idx_hi, idx_lo;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [width-1:0]    sel_a, sel_b;
    logic [3:0]          sel_fun;
    logic                accept;
    logic                rsp_accept;
    logic [NUM_REQ-1:0]  id_oh;
    logic [width2-1:0]   res_data;
    logic                res_flag;

    logic [width-1:0]    alu_a_q, alu_b_q;
    logic [3:0]          alu_fun_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [width2-1:0]   rsp_data_q;
    logic                rsp_flag_q;
    logic [2:0]          rsp_id_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign ptr = 3'd0;
`else
    logic [2:0] ptr_q, ptr_d;

    assign ptr_d = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 3'd0;
        end else if (accept) begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`endif

    // Lowest valid index at/after the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        grant_hit = 1'b0;
        hit_hi    = 1'b0;
        idx_hi    = 3'd0;
        idx_lo    = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_hit = 1'b1;
                idx_lo    = 3'(i);
                if (3'(i) >= ptr) begin
                    hit_hi = 1'b1;
                    idx_hi = 3'(i);
                end
            end
        end
        grant_idx = hit_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        grant_oh = '0;
        sel_a    = '0;
        sel_b    = '0;
        sel_fun  = '0;
        id_oh    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_hit && (grant_idx == 3'(i))) begin
                grant_oh[i] = 1'b1;
                sel_a       = req_a[i*width +: width];
                sel_b       = req_b[i*width +: width];
                sel_fun     = req_fun[i*4 +: 4];
            end
            id_oh[i] = (rsp_id_q == 3'(i));
        end
    end

    assign accept     = (state_q == IDLE) && grant_hit;
    // rsp_valid_q is one-hot on the owner, so non-owner ready bits mask out.
    assign rsp_accept = |(rsp_ready & rsp_valid_q);

    always_comb begin
        res_data = '0;
        res_flag = 1'b0;
        case (alu_fun_q[3:2])
            2'b00: begin
                res_data = alu_arith_out;
                res_flag = alu_arith_flag;
            end
            2'b01: begin
                res_data = width2'(alu_logic_out);
                res_flag = alu_logic_flag;
            end
            2'b10: begin
                res_data = width2'(alu_cmp_out);
                res_flag = alu_cmp_flag;
            end
            default: begin
                res_data = width2'(alu_shift_out);
                res_flag = alu_shift_flag;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_hit) state_d = EXEC;
            EXEC:    state_d = CAPT;
            CAPT:    state_d = RESP;
            RESP:    if (rsp_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_flag_q  <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_q   <= sel_a;
                alu_b_q   <= sel_b;
                alu_fun_q <= sel_fun;
                rsp_id_q  <= grant_idx;
            end
            if (state_q == CAPT) begin
                rsp_data_q  <= res_data;
                rsp_flag_q  <= res_flag;
                rsp_valid_q <= id_oh;
            end else if ((state_q == RESP) && rsp_accept) begin
                rsp_valid_q <= '0;
            end
        end
    end

    assign req_ready = (state_q == IDLE) ? grant_oh : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flag  = rsp_flag_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fun   = alu_fun_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with an ALU stub.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    logic        r_clk = 1'b0;
    logic        r_rst_n = 1'b1;
    logic [3:0]  r_req_valid = '0;
    logic [63:0] r_req_a = '0;
    logic [63:0] r_req_b = '0;
    logic [15:0] r_req_fun = '0;
    logic [3:0]  r_rsp_ready = '0;

    logic [3:0]  w_req_ready, w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_rsp_flag, w_busy;
    logic [2:0]  w_rsp_id;
    logic [15:0] w_alu_a, w_alu_b;
    logic [3:0]  w_alu_fun;

    logic [31:0] r_arith;
    logic [15:0] r_logic, r_cmp, r_shift;

    int n_total = 0;
    int n_bad   = 0;

    always #5 r_clk = ~r_clk;

    always_ff @(posedge r_clk) begin
        r_arith <= {16'd0, w_alu_a} + {16'd0, w_alu_b};
        r_logic <= w_alu_a & w_alu_b;
        r_cmp   <= {15'd0, (w_alu_a == w_alu_b)};
        r_shift <= w_alu_a >> 1;
    end

    alu_arbiter #(.width(16), .width2(32), .NUM_REQ(4)) u_dut (
        .clk            (r_clk),
        .reset          (r_rst_n),
        .req_valid      (r_req_valid),
        .req_ready      (w_req_ready),
        .req_a          (r_req_a),
        .req_b          (r_req_b),
        .req_fun        (r_req_fun),
        .rsp_valid      (w_rsp_valid),
        .rsp_ready      (r_rsp_ready),
        .rsp_data       (w_rsp_data),
        .rsp_flag       (w_rsp_flag),
        .rsp_id         (w_rsp_id),
        .busy           (w_busy),
        .alu_a          (w_alu_a),
        .alu_b          (w_alu_b),
        .alu_fun        (w_alu_fun),
        .alu_arith_out  (r_arith),
        .alu_arith_flag (r_arith != 32'd0),
        .alu_logic_out  (r_logic),
        .alu_cmp_out    (r_cmp),
        .alu_shift_out  (r_shift),
        .alu_logic_flag (r_logic != 16'd0),
        .alu_cmp_flag   (r_cmp != 16'd0),
        .alu_shift_flag (r_shift != 16'd0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(w_req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(w_rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  w_rsp_data, 32'd0);
        chk({tag, "_flag_id_busy"}, {27'd0, w_rsp_flag, w_rsp_id, w_busy}, 32'd0);
        chk({tag, "_alu_regs"}, {w_alu_a, w_alu_b}, 32'd0);
        chk({tag, "_alu_fun"}, 32'(w_alu_fun), 32'd0);
    endtask

    // Called just after a falling edge; fixed 3-cycle latency from the accept edge.
    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] fun, input logic [31:0] exp_d, input logic exp_f);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        r_req_a[idx*16 +: 16] = a;
        r_req_b[idx*16 +: 16] = b;
        r_req_fun[idx*4 +: 4] = fun;
        r_req_valid = oh;
        #1 chk("op_req_ready", 32'(w_req_ready), 32'(oh));
        @(negedge r_clk);
        chk("op_busy", 32'(w_busy), 32'd1);
        chk("op_alu_ab", {w_alu_a, w_alu_b}, {a, b});
        chk("op_alu_fun", 32'(w_alu_fun), 32'(fun));
        r_req_valid = '0;
        @(negedge r_clk);
        chk("op_no_early_rsp", 32'(w_rsp_valid), 32'd0);
        @(negedge r_clk);
        chk("op_rsp_valid", 32'(w_rsp_valid), 32'(oh));
        chk("op_rsp_data", w_rsp_data, exp_d);
        chk("op_rsp_flag", 32'(w_rsp_flag), 32'(exp_f));
        chk("op_rsp_id", 32'(w_rsp_id), 32'(idx));
        r_rsp_ready = oh;
        @(negedge r_clk);
        chk("op_rsp_done", {31'd0, w_busy} | 32'(w_rsp_valid), 32'd0);
        r_rsp_ready = '0;
    endtask

    initial begin
        int exp_order[5];
        int n;

        #1 r_rst_n = 1'b0;
        repeat (2) @(negedge r_clk);
        chk_all_zero("reset");
        r_rst_n = 1'b1;
        @(negedge r_clk);

        run_op(0, 16'd5, 16'd3, 4'b0000, 32'd8, 1'b1);
        run_op(2, 16'hF0F0, 16'h0FF0, 4'b0100, 32'h0000_00F0, 1'b1);

        repeat (20) begin
            @(negedge r_clk);
            chk("idle_busy_rsp", {27'd0, w_busy, w_rsp_valid}, 32'd0);
        end
        chk("idle_alu_ab", {w_alu_a, w_alu_b}, 32'hF0F0_0FF0);
        chk("idle_alu_fun", 32'(w_alu_fun), 32'd4);

        run_op(1, 16'h1234, 16'h1235, 4'b1000, 32'd0, 1'b0);
        run_op(3, 16'h8001, 16'h0000, 4'b1100, 32'h0000_4000, 1'b1);
        run_op(1, 16'hFFFF, 16'h0002, 4'b0011, 32'h0001_0001, 1'b1);

        // All four requesters continuously valid, responses accepted at once.
        r_rst_n = 1'b0;
        @(negedge r_clk);
        r_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r_req_a[i*16 +: 16] = 16'(i + 1);
            r_req_b[i*16 +: 16] = 16'(10 * i);
            r_req_fun[i*4 +: 4] = 4'b0000;
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        r_req_valid = 4'b1111;
        r_rsp_ready = 4'b1111;
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 5; cyc++) begin
            @(negedge r_clk);
            if (w_rsp_valid != 4'd0) begin
                chk("rr_id", 32'(w_rsp_id), 32'(exp_order[n]));
                chk("rr_data", w_rsp_data, 32'((exp_order[n] + 1) + 10 * exp_order[n]));
                n++;
            end
        end
        chk("rr_count", 32'(n), 32'd5);
        r_req_valid = '0;
        @(negedge r_clk);
        r_rsp_ready = '0;
        @(negedge r_clk);

        // Response stall with a competing request and a foreign rsp_ready pulse.
        r_rst_n = 1'b0;
        @(negedge r_clk);
        r_rst_n = 1'b1;
        r_req_a = '0;
        r_req_b = '0;
        r_req_fun = '0;
        r_req_a[15:0] = 16'd7;
        r_req_b[15:0] = 16'd9;
        r_req_a[31:16] = 16'h0011;
        r_req_b[31:16] = 16'h0022;
        r_req_fun[7:4] = 4'b0100;
        r_req_valid = 4'b0001;
        @(negedge r_clk);
        r_req_valid = 4'b0010;
        repeat (2) @(negedge r_clk);
        for (int k = 0; k < 10; k++) begin
            chk("stall_rsp_valid", 32'(w_rsp_valid), 32'd1);
            chk("stall_data", w_rsp_data, 32'd16);
            chk("stall_id_busy", {28'd0, w_rsp_id, w_busy}, 32'd1);
            chk("stall_req_ready", 32'(w_req_ready), 32'd0);
            r_rsp_ready = (k == 4) ? 4'b0010 : 4'b0000;
            @(negedge r_clk);
        end
        r_rsp_ready = 4'b0001;
        @(negedge r_clk);
        r_rsp_ready = '0;
        chk("stall_released", 32'(w_rsp_valid), 32'd0);
        chk("stall_next_grant", 32'(w_req_ready), 32'b0010);
        @(negedge r_clk);
        r_req_valid = '0;
        chk("exec_alu_ab", {w_alu_a, w_alu_b}, 32'h0011_0022);

        // Asynchronous reset while in EXEC.
        #2 r_rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge r_clk);
        r_rst_n = 1'b1;
        repeat (6) begin
            @(negedge r_clk);
            chk("post_rst_quiet", {27'd0, w_busy, w_rsp_valid}, 32'd0);
        end
        r_req_valid = 4'b1010;
        #1 chk("post_rst_grant", 32'(w_req_ready), 32'b0010);
        r_req_valid = '0;
        @(negedge r_clk);
        chk("post_rst_idle", 32'(w_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
